// File: rtl/rip_pipe_ctrl.sv
// rip_pipe_ctrl: pipeline hazard/stall controller for the RIP core.
// Arbitrates redirects, memory back-pressure, multi-cycle mul/div occupancy
// and load-use bubbles, and counts stall cycles.
// Optional feature macro: RIP_MULDIV_EN (enables MD_BUSY, the occupancy
// counter, md_start and md_last; otherwise those outputs are tied low).
// Control outputs are combinational so a redirect kills decode in the same
// cycle; all of them are held low while rst_n is low.

module rip_pipe_ctrl #(
    parameter int unsigned REG_ADDR_WIDTH = 5,
    parameter int unsigned MD_CYCLES      = 33
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      if_valid,
    input  logic [REG_ADDR_WIDTH-1:0] if_rs1_num,
    input  logic [REG_ADDR_WIDTH-1:0] if_rs2_num,
    input  logic [REG_ADDR_WIDTH-1:0] de_rd_num,
    input  logic                      de_is_load,
    input  logic                      de_is_muldiv,
    input  logic                      ex_branch_taken,
    input  logic                      mem_busy,
    output logic                      de_ready,
    output logic                      ex_stall,
    output logic                      flush,
    output logic                      md_start,
    output logic                      md_last,
    output logic [31:0]               stall_count
);

    localparam int unsigned CNT_W   = 8;
    localparam int unsigned STALL_W = 32;

`ifdef RIP_MULDIV_EN
    typedef enum logic [1:0] {
        ST_RUN      = 2'd0,
        ST_MD_BUSY  = 2'd1,
        ST_REDIRECT = 2'd2
    } state_e;

    logic [CNT_W-1:0] md_cnt_q;
    logic [CNT_W-1:0] md_cnt_d;
`else
    typedef enum logic [1:0] {
        ST_RUN      = 2'd0,
        ST_REDIRECT = 2'd2
    } state_e;

    // Mul/div support is compiled out; these inputs intentionally go nowhere.
    localparam int unsigned UNUSED_MD_CYCLES = MD_CYCLES;
    logic unused_muldiv;
    assign unused_muldiv = de_is_muldiv;
`endif

    state_e               state_q;
    state_e               state_d;
    logic [STALL_W-1:0]   stall_count_q;
    logic                 load_use_c;
    logic                 stall_inc_c;

    // Load-use hazard: fetched instruction reads the register a load is writing.
    assign load_use_c = if_valid && de_is_load && (de_rd_num != '0) &&
                        ((if_rs1_num == de_rd_num) || (if_rs2_num == de_rd_num));

    // A stall cycle is a decode hold on a valid fetch, or any EX hold.
    assign stall_inc_c = (!de_ready && if_valid) || ex_stall;

    assign stall_count = stall_count_q;

    // Next-state and control outputs; everything forced low during reset.
    always_comb begin
        state_d  = state_q;
        de_ready = 1'b0;
        ex_stall = 1'b0;
        flush    = 1'b0;
        md_start = 1'b0;
        md_last  = 1'b0;
`ifdef RIP_MULDIV_EN
        md_cnt_d = md_cnt_q;
`endif
        if (rst_n) begin
            unique case (state_q)
                ST_RUN: begin
                    if (ex_branch_taken) begin
                        flush   = 1'b1;
                        state_d = ST_REDIRECT;
                    end else if (mem_busy) begin
                        ex_stall = 1'b1;
`ifdef RIP_MULDIV_EN
                    end else if (de_is_muldiv) begin
                        // Launch cycle counts as the first EX occupancy cycle.
                        md_start = 1'b1;
                        ex_stall = 1'b1;
                        md_cnt_d = CNT_W'(MD_CYCLES - 1);
                        state_d  = ST_MD_BUSY;
`endif
                    end else if (load_use_c) begin
                        de_ready = 1'b0;
                    end else begin
                        de_ready = if_valid;
                    end
                end
`ifdef RIP_MULDIV_EN
                ST_MD_BUSY: begin
                    // Counter reaching zero on this edge marks the final cycle.
                    ex_stall = 1'b1;
                    md_cnt_d = md_cnt_q - CNT_W'(1);
                    if (md_cnt_q == CNT_W'(1)) begin
                        md_last = 1'b1;
                        state_d = ST_RUN;
                    end
                end
`endif
                ST_REDIRECT: begin
                    flush   = 1'b1;
                    state_d = ST_RUN;
                end
                default: begin
                    state_d = ST_RUN;
                end
            endcase
        end
    end

    // State, occupancy counter and wrapping stall counter (synchronous reset).
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q       <= ST_RUN;
            stall_count_q <= '0;
`ifdef RIP_MULDIV_EN
            md_cnt_q      <= '0;
`endif
        end else begin
            state_q       <= state_d;
            stall_count_q <= stall_count_q + STALL_W'(stall_inc_c);
`ifdef RIP_MULDIV_EN
            md_cnt_q      <= md_cnt_d;
`endif
        end
    end

endmodule

// File: doc/rip_pipe_ctrl.md
RIP_PIPE_CTRL -- requirements
Module: rip_pipe_ctrl

Interface
REQ-001 SHALL have parameter REG_ADDR_WIDTH, default 5, register-number width.
REQ-002 SHALL have parameter MD_CYCLES, default 33, EX occupancy in cycles of one M-extension op; legal range 2..255.
REQ-003 SHALL have port clk, input, 1, clock.
REQ-004 SHALL have port rst_n, input, 1, reset; synchronous, active-low.
REQ-005 SHALL have port if_valid, input, 1, fetched instruction present at decode input.
REQ-006 SHALL have ports if_rs1_num and if_rs2_num, input, REG_ADDR_WIDTH, source registers of the fetched instruction.
REQ-007 SHALL have port de_rd_num, input, REG_ADDR_WIDTH, destination of the instruction in decode/EX.
REQ-008 SHALL have port de_is_load, input, 1, decoded instruction is LB/LH/LW/LBU/LHU.
REQ-009 SHALL have port de_is_muldiv, input, 1, decoded instruction is any RV32M op.
REQ-010 SHALL have port ex_branch_taken, input, 1, EX redirect (taken branch, jump or mispredict).
REQ-011 SHALL have port mem_busy, input, 1, data memory not ready.
REQ-012 SHALL have ports de_ready and ex_stall, output, 1, decode-stage enable and EX hold.
REQ-013 SHALL have port flush, output, 1, kill fetched and decoding instructions.
REQ-014 SHALL have port md_start, output, 1, one-cycle pulse launching a mul/div op.
REQ-015 SHALL have port md_last, output, 1, final cycle of a mul/div op.
REQ-016 SHALL have port stall_count, output, 32, total stall cycles, wrapping.

Function
REQ-017 SHALL implement FSM states RUN, MD_BUSY and REDIRECT.
REQ-018 SHALL evaluate RUN with priority ex_branch_taken > mem_busy > muldiv entry > load-use > normal issue.
REQ-019 SHALL, in RUN on ex_branch_taken: assert flush=1 and de_ready=0 combinationally in the same cycle, then go to REDIRECT.
REQ-020 SHALL, in REDIRECT: assert flush=1 and de_ready=0 for exactly one cycle, then return to RUN.
REQ-021 SHALL, in RUN on mem_busy: assert ex_stall=1 and de_ready=0, and remain in RUN.
REQ-022 SHALL, in RUN with de_is_muldiv=1: pulse md_start, load the counter with MD_CYCLES-1 and go to MD_BUSY.
REQ-023 SHALL, in MD_BUSY: hold ex_stall=1 and de_ready=0, and decrement the counter each cycle.
REQ-024 SHALL, in MD_BUSY when the counter reaches 0: assert md_last=1 and return to RUN on the next edge; EX occupancy from md_start through md_last is exactly MD_CYCLES cycles.
REQ-025 SHALL ignore ex_branch_taken and mem_busy in MD_BUSY.
REQ-026 SHALL detect a load-use hazard as if_valid && de_is_load && de_rd_num!=0 && (if_rs1_num==de_rd_num || if_rs2_num==de_rd_num).
REQ-027 SHALL, on a load-use hazard: drive de_ready=0 and ex_stall=0 for one cycle (decode injects a bubble), and remain in RUN.
REQ-028 SHALL, on normal issue: drive de_ready=if_valid and ex_stall=0.
REQ-029 SHALL increment stall_count once per cycle whenever de_ready=0 and if_valid=1, or ex_stall=1; counts wrap from 0xFFFFFFFF to 0.

Reset
REQ-030 SHALL, while rst_n=0: set the state to RUN, the counter to 0 and stall_count to 0, and force de_ready, ex_stall, flush, md_start and md_last to 0.
REQ-031 SHALL, when reset occurs mid MD_BUSY or REDIRECT, abandon the operation with no md_last pulse; RUN operation resumes on the first cycle after rst_n=1.

Configuration
REQ-032 SHALL use macro RIP_MULDIV_EN.
REQ-033 SHALL, with RIP_MULDIV_EN defined: implement MD_BUSY, the counter, md_start and md_last as specified above.
REQ-034 SHALL, with RIP_MULDIV_EN undefined: omit MD_BUSY and the counter, ignore de_is_muldiv, and tie md_start and md_last to 0.

Verification
REQ-035 SHALL cover: reset release, if_valid=1, no hazards -> de_ready=1, ex_stall=0, flush=0, stall_count=0.
REQ-036 SHALL cover: de_is_load=1, de_rd_num=5, if_rs2_num=5 -> one cycle de_ready=0, ex_stall=0, stall_count+1; de_rd_num=0 gives no stall.
REQ-037 SHALL cover: de_is_muldiv=1 with MD_CYCLES=33 -> md_start for 1 cycle, ex_stall=1 for 33 cycles, md_last on the 33rd, then RUN.
REQ-038 SHALL cover: ex_branch_taken=1 together with mem_busy=1 in RUN -> flush=1 for 2 cycles, ex_stall=0.
REQ-039 SHALL cover: rst_n=0 in the 10th MD_BUSY cycle -> all outputs 0, no md_last, RUN after release.
REQ-040 SHALL cover: stall_count preset to 0xFFFFFFFF by force, one stall cycle -> stall_count=0.
